// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle HI/LO multiply/divide unit for a classic 5-stage MIPS-style pipeline.
//
// Operations (md_op): 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 0 and 7 are ignored.
// mult/div latch their operands on the issue edge and run for a fixed number of cycles.
// HI/LO are written only on the completing edge. mthi/mtlo write HI/LO directly on the
// issue edge.
//
// Ports:
//   clk    input   1   clock, rising-edge
//   reset  input   1   synchronous active-high reset
//   start  input   1   one-cycle issue strobe from EX
//   md_op  input   3   operation select
//   a      input  32   RS operand
//   b      input  32   RT operand
//   busy   output  1   operation in progress; the ID stage stalls on (start | busy)
//   done   output  1   one-cycle pulse after HI/LO are written by mult/div
//   hi     output 32   HI register
//   lo     output 32   LO register
//
// Parameters:
//   MULT_CYCLES  busy duration for mult/multu (1..16)
//   DIV_CYCLES   busy duration for div/divu (1..16)

module mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    // The counter is loaded with N-1 so that RUN lasts exactly N cycles.
    localparam logic [3:0] MultLoad = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES - 1);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        issue_md;    // mult/div accepted this cycle
    logic        issue_mthi;
    logic        issue_mtlo;
    logic        complete;    // last RUN cycle; HI/LO written at the coming edge
    logic        op_is_mult;

    // ------------------------------------------------------------------
    // Issue decode. Only IDLE accepts anything; start while RUN is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        issue_md   = 1'b0;
        issue_mthi = 1'b0;
        issue_mtlo = 1'b0;
        if (state_q == StIdle && start) begin
            issue_md   = (md_op == OpMult) || (md_op == OpMultu) ||
                         (md_op == OpDiv)  || (md_op == OpDivu);
            issue_mthi = (md_op == OpMthi);
            issue_mtlo = (md_op == OpMtlo);
        end
    end

    assign complete   = (state_q == StRun) && (cnt_q == 4'd0);
    assign op_is_mult = (op_q == OpMult) || (op_q == OpMultu);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (issue_md) begin
                    state_d = StRun;
                    cnt_d   = ((md_op == OpMult) || (md_op == OpMultu)) ? MultLoad : DivLoad;
                end
            end
            StRun: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. busy comes straight from state, so there is no
    // combinational path from start/a/b to it.
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q == StRun);
    end

    // ------------------------------------------------------------------
    // Datapath. Results depend only on the latched operands.
    // ------------------------------------------------------------------

    // A 64-bit product of sign- or zero-extended operands gives the correct low 64 bits
    // for both the signed and unsigned cases.
    logic        mul_signed;
    logic [63:0] mul_a, mul_b;
    logic [63:0] product;

    always_comb begin
        mul_signed = (op_q == OpMult);
        mul_a      = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        mul_b      = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        product    = mul_a * mul_b;
    end

    // Signed division via magnitudes: the quotient truncates toward zero and the remainder
    // takes the dividend's sign. 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    logic        div_signed;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe;
    logic [31:0] quot_mag, rem_mag;
    logic [31:0] quotient, remainder;
    logic        div_by_zero;

    always_comb begin
        div_signed  = (op_q == OpDiv);
        a_neg       = div_signed && a_q[31];
        b_neg       = div_signed && b_q[31];
        a_mag       = a_neg ? (32'd0 - a_q) : a_q;
        b_mag       = b_neg ? (32'd0 - b_q) : b_q;
        div_by_zero = (b_q == 32'd0);
        // Keep the divider's operand non-zero; its result is discarded on divide-by-zero.
        b_safe      = div_by_zero ? 32'd1 : b_mag;
        quot_mag    = a_mag / b_safe;
        rem_mag     = a_mag % b_safe;
        quotient    = (a_neg ^ b_neg) ? (32'd0 - quot_mag) : quot_mag;
        remainder   = a_neg ? (32'd0 - rem_mag) : rem_mag;
    end

    // ------------------------------------------------------------------
    // HI/LO/done next-state
    // ------------------------------------------------------------------
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        if (complete) begin
            done_d = 1'b1;
            if (op_is_mult) begin
                hi_d = product[63:32];
                lo_d = product[31:0];
            end else if (!div_by_zero) begin
                hi_d = remainder;
                lo_d = quotient;
            end
        end else if (issue_mthi) begin
            hi_d = a;
        end else if (issue_mtlo) begin
            lo_d = a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

    // Operand/op latch; only loaded on an accepted mult/div issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= 3'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
        end else if (issue_md) begin
            op_q <= md_op;
            a_q  <= a;
            b_q  <= b;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

endmodule
